wb_commit_stage: RTL and testbench
==================================

Name: wb_commit_stage

Overview:
Parametrised successor to the single-token write-back stage of the multi-cycle RV32I core. It commits one instruction per accepted handshake: it updates the architectural PC, drives the register-file write port and redirects to a trap vector on a trap or a misaligned target. It also counts retired instructions and emits the commit token that restarts fetch. It is the last stage of the pipeline and feeds fetch and the register file.

Parameters:
XLEN, 32, datapath and PC width
RESET_PC, 32'h0000_8000, PC value loaded on reset
REG_AW, 5, register index width
CNT_W, 64, retire counter width

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-low
in_valid  in  1  execute stage presents an instruction
in_ready  out  1  stage can accept the instruction
in_pc_next  in  XLEN  next PC computed upstream
in_rd  in  REG_AW  destination register
in_rd_we  in  1  instruction writes rd
in_rd_data  in  XLEN  write-back data
in_trap  in  1  instruction raised a trap
in_halt  in  1  instruction is a halt (ebreak)
trap_vec  in  XLEN  trap target; bits [1:0] are ignored
stall  in  1  external hold
pc  out  XLEN  architectural PC
rf_we  out  1  register-file write strobe
rf_waddr  out  REG_AW  write address
rf_wdata  out  XLEN  write data
commit_out  out  1  one-cycle token to fetch
misalign  out  1  one-cycle flag for a misaligned target
retire_cnt  out  CNT_W  retired-instruction count
halted  out  1  core halted

Behaviour:
- Reset is rst, asynchronous and active-low, on clock clk.
- While rst is low: pc=RESET_PC, state=BOOT, and all strobes, misalign, halted and retire_cnt are 0.
- rf_waddr and rf_wdata reset to 0.
- States:
  - BOOT: lasts one cycle after reset release. Asserts commit_out for one cycle with pc=RESET_PC. Always goes to RUN. in_ready=0.
  - RUN: in_ready = ~stall. An accept happens when in_valid & in_ready.
  - HALT: in_ready=0, halted=1. Inputs are ignored. Only reset leaves this state.
- On an accept in RUN, all effects are registered and visible in the next cycle (latency 1):
  - Trap case (in_trap=1): pc <= {trap_vec[XLEN-1:2],2'b00}. No rf write. retire_cnt unchanged.
  - Misaligned case (in_trap=0 and in_pc_next[1:0]!=0): treated as a trap. pc <= aligned trap_vec. misalign=1 for one cycle. No rf write. retire_cnt unchanged.
  - Normal case: pc <= in_pc_next. rf_we=1 for one cycle only if in_rd_we=1 and in_rd!=0. rf_waddr/rf_wdata <= in_rd/in_rd_data. retire_cnt increments.
  - commit_out=1 for one cycle on every accept, including trap cases.
- in_halt=1 on an accept:
  - The instruction commits normally: pc update, rf write and retire count.
  - The state then moves to HALT and halted=1 from the next cycle.
  - in_trap has priority over in_halt; a trapping halt stays in RUN.
- No accept: pc, rf_waddr and rf_wdata hold. rf_we, commit_out and misalign are 0.
- stall=1 drops in_ready in the same cycle (combinational). The upstream stage must hold its inputs.
- retire_cnt wraps modulo 2^CNT_W without any flag.
- rf_we and commit_out never assert in BOOT or HALT.
- Reset asserted mid-operation clears all state immediately. Any in-flight commit is lost.

Test Plan:
- Reset release -> cycle 1: commit_out=1, pc=0x8000, in_ready=0. Cycle 2: in_ready=1.
- Accept pc_next=0x8004, rd=5, we=1, data=0xDEADBEEF -> next cycle: pc=0x8004, rf_we=1, rf_waddr=5, rf_wdata=0xDEADBEEF, retire_cnt=1, commit_out=1.
- Accept rd=0, we=1 -> rf_we=0, retire_cnt increments, pc updates.
- Trap with trap_vec=0x103 -> pc=0x100, rf_we=0, retire_cnt unchanged. Then pc_next=0x8006 with no trap -> pc=0x100, misalign=1.
- in_valid=1 with stall=1 for 3 cycles -> in_ready=0, pc holds, no strobes. Release stall -> exactly one accept.
- Accept halt with pc_next=0x8010 -> pc=0x8010, halted=1, in_ready=0 thereafter. Then rst pulse low -> pc=0x8000 and the BOOT token is emitted again.

Source files
------------

// File: rtl/wb_commit_stage.sv
`default_nettype none
// ============================================================================
//  Module      : wb_commit_stage
//  Description : Write-back / commit stage. Retires one instruction per
//                accepted handshake: updates the architectural PC, drives the
//                register-file write port, redirects to the trap vector on a
//                trap or misaligned target, counts retired instructions and
//                emits the commit token that restarts fetch.
//  Revision    : 1.0 - initial release
// ============================================================================
module wb_commit_stage #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = 'h0000_8000,
  parameter int              REG_AW   = 5,
  parameter int              CNT_W    = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   in_pc_next,
  input  logic [REG_AW-1:0] in_rd,
  input  logic              in_rd_we,
  input  logic [XLEN-1:0]   in_rd_data,
  input  logic              in_trap,
  input  logic              in_halt,
  input  logic [XLEN-1:0]   trap_vec,
  input  logic              stall,
  output logic [XLEN-1:0]   pc,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_waddr,
  output logic [XLEN-1:0]   rf_wdata,
  output logic              commit_out,
  output logic              misalign,
  output logic [CNT_W-1:0]  retire_cnt,
  output logic              halted
);

  localparam logic [REG_AW-1:0] c_REG_ZERO = '0;
  localparam logic [CNT_W-1:0]  c_CNT_ONE  = CNT_W'(1);

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;

  logic [XLEN-1:0]   r_pc;
  logic              r_rf_we;
  logic [REG_AW-1:0] r_rf_waddr;
  logic [XLEN-1:0]   r_rf_wdata;
  logic              r_commit;
  logic              r_misalign;
  logic [CNT_W-1:0]  r_retire_cnt;

  logic              w_ready;
  logic              w_accept;
  logic              w_misaligned;
  logic              w_trap_like;
  logic              w_boot_tok;
  logic [XLEN-1:0]   w_trap_target;
  logic              w_unused_bits;

  // Handshake: only RUN accepts, and stall gates ready combinationally.
  assign w_ready  = (r_state == ST_RUN) && !stall;
  assign w_accept = w_ready && in_valid;

  // A misaligned target is only considered when no explicit trap is raised,
  // so the misalign flag never fires for a genuine trap.
  assign w_misaligned  = !in_trap && (in_pc_next[1:0] != 2'b00);
  assign w_trap_like   = in_trap || w_misaligned;
  assign w_trap_target = {trap_vec[XLEN-1:2], 2'b00};

  // The BOOT token fires on the first edge after reset release; r_commit
  // then being set is what moves BOOT on to RUN one cycle later.
  assign w_boot_tok = (r_state == ST_BOOT) && !r_commit;

  // Low trap_vec bits are dropped by alignment.
  assign w_unused_bits = &{1'b0, trap_vec[1:0]};

  // State register with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic: BOOT for one token cycle, RUN until a clean halt retires.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_BOOT: begin
        if (r_commit) begin
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (w_accept && in_halt && !w_trap_like) begin
          w_state_nxt = ST_HALT;
        end
      end
      ST_HALT: begin
        w_state_nxt = ST_HALT;
      end
      default: begin
        w_state_nxt = ST_BOOT;
      end
    endcase
  end

  // Commit datapath: PC, register-file port, strobes and retire counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc         <= RESET_PC;
      r_rf_we      <= 1'b0;
      r_rf_waddr   <= '0;
      r_rf_wdata   <= '0;
      r_commit     <= 1'b0;
      r_misalign   <= 1'b0;
      r_retire_cnt <= '0;
    end else begin
      r_rf_we    <= 1'b0;
      r_misalign <= 1'b0;
      r_commit   <= w_boot_tok || w_accept;
      if (w_accept) begin
        if (w_trap_like) begin
          r_pc       <= w_trap_target;
          r_misalign <= w_misaligned;
        end else begin
          r_pc         <= in_pc_next;
          r_rf_we      <= in_rd_we && (in_rd != c_REG_ZERO);
          r_rf_waddr   <= in_rd;
          r_rf_wdata   <= in_rd_data;
          r_retire_cnt <= r_retire_cnt + c_CNT_ONE;
        end
      end
    end
  end

  assign in_ready   = w_ready;
  assign pc         = r_pc;
  assign rf_we      = r_rf_we;
  assign rf_waddr   = r_rf_waddr;
  assign rf_wdata   = r_rf_wdata;
  assign commit_out = r_commit;
  assign misalign   = r_misalign;
  assign retire_cnt = r_retire_cnt;
  assign halted     = (r_state == ST_HALT);

endmodule
`default_nettype wire

// File: tb/tb_wb_commit_stage.sv
`default_nettype none
// ============================================================================
//  Module      : tb_wb_commit_stage
//  Description : Directed, table-driven bench for wb_commit_stage plus
//                hand-written reset sequences.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wb_commit_stage;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc_next;
  logic [4:0]  in_rd;
  logic        in_rd_we;
  logic [31:0] in_rd_data;
  logic        in_trap;
  logic        in_halt;
  logic [31:0] trap_vec;
  logic        stall;
  logic [31:0] pc;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        commit_out;
  logic        misalign;
  logic [63:0] retire_cnt;
  logic        halted;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    bit          valid;
    bit          stl;
    logic [31:0] pc_next;
    logic [4:0]  rd;
    bit          we;
    logic [31:0] data;
    bit          trap;
    bit          halt;
    logic [31:0] tvec;
    bit          e_ready;
    logic [31:0] e_pc;
    bit          e_we;
    logic [4:0]  e_waddr;
    logic [31:0] e_wdata;
    bit          e_commit;
    bit          e_mis;
    logic [63:0] e_retire;
    bit          e_halted;
  } vec_t;

  vec_t vecs[$];

  wb_commit_stage dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc_next (in_pc_next),
    .in_rd      (in_rd),
    .in_rd_we   (in_rd_we),
    .in_rd_data (in_rd_data),
    .in_trap    (in_trap),
    .in_halt    (in_halt),
    .trap_vec   (trap_vec),
    .stall      (stall),
    .pc         (pc),
    .rf_we      (rf_we),
    .rf_waddr   (rf_waddr),
    .rf_wdata   (rf_wdata),
    .commit_out (commit_out),
    .misalign   (misalign),
    .retire_cnt (retire_cnt),
    .halted     (halted)
  );

  // Free-running clock, period 10.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Guard against a runaway simulation.
  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h required 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input vec_t v);
    in_valid   = v.valid;
    stall      = v.stl;
    in_pc_next = v.pc_next;
    in_rd      = v.rd;
    in_rd_we   = v.we;
    in_rd_data = v.data;
    in_trap    = v.trap;
    in_halt    = v.halt;
    trap_vec   = v.tvec;
  endtask

  task automatic idle();
    in_valid = 0; stall = 0; in_pc_next = 0; in_rd = 0; in_rd_we = 0;
    in_rd_data = 0; in_trap = 0; in_halt = 0; trap_vec = 0;
  endtask

  task automatic chk_outs(input string tag, input vec_t v);
    chk({tag, ".pc"},         64'(pc),         64'(v.e_pc));
    chk({tag, ".rf_we"},      64'(rf_we),      64'(v.e_we));
    chk({tag, ".rf_waddr"},   64'(rf_waddr),   64'(v.e_waddr));
    chk({tag, ".rf_wdata"},   64'(rf_wdata),   64'(v.e_wdata));
    chk({tag, ".commit_out"}, 64'(commit_out), 64'(v.e_commit));
    chk({tag, ".misalign"},   64'(misalign),   64'(v.e_mis));
    chk({tag, ".retire_cnt"}, retire_cnt,      v.e_retire);
    chk({tag, ".halted"},     64'(halted),     64'(v.e_halted));
  endtask

  initial begin
    // valid stl pc_next rd we data trap halt tvec | ready pc we waddr wdata commit mis retire halted
    vecs.push_back('{0,0,32'h0,    0,0,32'h0,        0,0,32'h0,   0,32'h8000,0,0,32'h0,        1,0,0,0}); // BOOT token
    vecs.push_back('{0,0,32'h0,    0,0,32'h0,        0,0,32'h0,   0,32'h8000,0,0,32'h0,        0,0,0,0}); // BOOT -> RUN
    vecs.push_back('{1,0,32'h8004, 5,1,32'hDEADBEEF, 0,0,32'h0,   1,32'h8004,1,5,32'hDEADBEEF, 1,0,1,0}); // normal write
    vecs.push_back('{1,0,32'h8008, 0,1,32'h1111,     0,0,32'h0,   1,32'h8008,0,0,32'h1111,     1,0,2,0}); // rd=0 suppressed
    vecs.push_back('{1,0,32'h800C, 7,1,32'h2222,     1,0,32'h103, 1,32'h100, 0,0,32'h1111,     1,0,2,0}); // trap
    vecs.push_back('{1,0,32'h8006, 8,1,32'h2323,     0,0,32'h103, 1,32'h100, 0,0,32'h1111,     1,1,2,0}); // misaligned
    vecs.push_back('{0,0,32'h0,    0,0,32'h0,        0,0,32'h103, 1,32'h100, 0,0,32'h1111,     0,0,2,0}); // idle
    vecs.push_back('{1,1,32'h200,  3,1,32'h3333,     0,0,32'h103, 0,32'h100, 0,0,32'h1111,     0,0,2,0}); // stall 1
    vecs.push_back('{1,1,32'h200,  3,1,32'h3333,     0,0,32'h103, 0,32'h100, 0,0,32'h1111,     0,0,2,0}); // stall 2
    vecs.push_back('{1,1,32'h200,  3,1,32'h3333,     0,0,32'h103, 0,32'h100, 0,0,32'h1111,     0,0,2,0}); // stall 3
    vecs.push_back('{1,0,32'h200,  3,1,32'h3333,     0,0,32'h103, 1,32'h200, 1,3,32'h3333,     1,0,3,0}); // stall released
    vecs.push_back('{0,0,32'h0,    0,0,32'h0,        0,0,32'h103, 1,32'h200, 0,3,32'h3333,     0,0,3,0}); // single accept only
    vecs.push_back('{1,0,32'h8014, 2,1,32'h6666,     1,1,32'h42,  1,32'h40,  0,3,32'h3333,     1,0,3,0}); // trapping halt stays RUN
    vecs.push_back('{1,0,32'h8010, 4,1,32'h4444,     0,1,32'h42,  1,32'h8010,1,4,32'h4444,     1,0,4,1}); // halt commits
    vecs.push_back('{1,0,32'h9000, 6,1,32'h5555,     0,0,32'h0,   0,32'h8010,0,4,32'h4444,     0,0,4,1}); // halted ignores
    vecs.push_back('{1,0,32'h9000, 6,1,32'h5555,     0,0,32'h0,   0,32'h8010,0,4,32'h4444,     0,0,4,1}); // still halted

    // Reset state.
    rst = 1'b0;
    idle();
    repeat (3) @(posedge clk);
    #1;
    chk("rst.pc",         64'(pc),         64'h8000);
    chk("rst.rf_we",      64'(rf_we),      64'h0);
    chk("rst.rf_waddr",   64'(rf_waddr),   64'h0);
    chk("rst.rf_wdata",   64'(rf_wdata),   64'h0);
    chk("rst.commit_out", 64'(commit_out), 64'h0);
    chk("rst.misalign",   64'(misalign),   64'h0);
    chk("rst.retire_cnt", retire_cnt,      64'h0);
    chk("rst.halted",     64'(halted),     64'h0);
    chk("rst.in_ready",   64'(in_ready),   64'h0);

    @(negedge clk);
    rst = 1'b1;

    // Table: ready is sampled before the edge, registered outputs after it.
    for (int i = 0; i < vecs.size(); i++) begin
      if (i != 0) @(negedge clk);
      drive(vecs[i]);
      #1;
      chk($sformatf("v%0d.in_ready", i), 64'(in_ready), 64'(vecs[i].e_ready));
      @(posedge clk);
      #1;
      chk_outs($sformatf("v%0d", i), vecs[i]);
    end

    // Asynchronous reset out of HALT clears state without a clock edge.
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("arst.pc",         64'(pc),         64'h8000);
    chk("arst.halted",     64'(halted),     64'h0);
    chk("arst.retire_cnt", retire_cnt,      64'h0);
    chk("arst.rf_waddr",   64'(rf_waddr),   64'h0);
    chk("arst.rf_wdata",   64'(rf_wdata),   64'h0);
    chk("arst.in_ready",   64'(in_ready),   64'h0);
    @(posedge clk);
    #1;
    chk("arst.commit_out", 64'(commit_out), 64'h0);

    // Reboot with in_valid held high: BOOT must ignore it and emit the token.
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("boot0.in_ready", 64'(in_ready), 64'h0);
    @(posedge clk);
    #1;
    chk("boot1.commit_out", 64'(commit_out), 64'h1);
    chk("boot1.pc",         64'(pc),         64'h8000);
    chk("boot1.in_ready",   64'(in_ready),   64'h0);
    @(posedge clk);
    #1;
    chk("boot2.commit_out", 64'(commit_out), 64'h0);
    chk("boot2.in_ready",   64'(in_ready),   64'h1);
    chk("boot2.retire_cnt", retire_cnt,      64'h0);

    // In-flight accept lost to a reset asserted before the edge.
    @(negedge clk);
    in_valid = 1; in_pc_next = 32'h8020; in_rd = 9; in_rd_we = 1; in_rd_data = 32'h7777;
    #2;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("lost.pc",         64'(pc),         64'h8000);
    chk("lost.rf_we",      64'(rf_we),      64'h0);
    chk("lost.rf_waddr",   64'(rf_waddr),   64'h0);
    chk("lost.retire_cnt", retire_cnt,      64'h0);
    chk("lost.commit_out", 64'(commit_out), 64'h0);
    idle();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("lost.boot_token", 64'(commit_out), 64'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
